// File: rtl/axi_rd_arbiter.sv
// N-master to 1-slave AXI4 read-channel arbiter.
// One burst in flight; round-robin or fixed-priority grant.
module axi_rd_arbiter #(
  parameter int NUM_MST  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_MST-1:0]        s_arvalid,
  input  logic [NUM_MST*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MST*8-1:0]      s_arlen,
  input  logic [NUM_MST*3-1:0]      s_arsize,
  input  logic [NUM_MST*2-1:0]      s_arburst,
  output logic [NUM_MST-1:0]        s_arready,
  output logic [NUM_MST-1:0]        s_rvalid,
  input  logic [NUM_MST-1:0]        s_rready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic [ID_W-1:0]           m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic [1:0]                m_arlock,
  output logic [3:0]                m_arcache,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [ID_W-1:0]           m_rid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam logic [GW-1:0] LAST = GW'(NUM_MST - 1);
  localparam logic [GW:0] NUM_W = (GW + 1)'(NUM_MST);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state, state_d;
  logic [GW-1:0] grant, grant_d;
  logic [GW-1:0] last_grant, last_grant_d;
  logic [GW-1:0] rr_start, rr_off, rr_sel;
  logic [GW-1:0] fp_sel, win;
  logic [NUM_MST-1:0] req_rot;
  logic [GW:0]   rr_sum;

  // rotate requests so bit 0 is the master after last_grant
  assign rr_start = (last_grant == LAST) ? '0 : last_grant + 1'b1;
  assign req_rot  = NUM_MST'({s_arvalid, s_arvalid} >> rr_start);
  assign rr_sum   = {1'b0, rr_start} + {1'b0, rr_off};
  assign rr_sel   = (rr_sum >= NUM_W) ? GW'(rr_sum - NUM_W)
                                      : GW'(rr_sum);
  assign win      = (ARB_MODE != 0) ? fp_sel : rr_sel;

  always_comb begin
    rr_off = '0;
    fp_sel = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (req_rot[i])   rr_off = GW'(i);
      if (s_arvalid[i]) fp_sel = GW'(i);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    m_arvalid    = 1'b0;
    m_arid       = '0;
    m_araddr     = '0;
    m_arlen      = '0;
    m_arsize     = '0;
    m_arburst    = '0;
    m_rready     = 1'b0;
    s_arready    = '0;
    s_rvalid     = '0;
    unique case (state)
      IDLE: begin
        if (|s_arvalid) begin
          grant_d = win;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_arvalid        = 1'b1;
        m_arid           = ID_W'(grant);
        m_araddr         = s_araddr[grant*ADDR_W +: ADDR_W];
        m_arlen          = s_arlen[grant*8 +: 8];
        m_arsize         = s_arsize[grant*3 +: 3];
        m_arburst        = s_arburst[grant*2 +: 2];
        s_arready[grant] = m_arready;
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        s_rvalid[grant] = m_rvalid;
        m_rready        = s_rready[grant];
        if (m_rvalid && s_rready[grant] && m_rlast) begin
          last_grant_d = grant;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign m_arlock  = '0;
  assign m_arcache = '0;
  assign m_arprot  = '0;

  a_ar_hold: assert property (@(posedge aclk) disable iff (areset)
    (state == ADDR) |-> s_arvalid[grant]);

  a_rid: assert property (@(posedge aclk) disable iff (areset)
    (state == DATA && m_rvalid) |-> (m_rid == ID_W'(grant)));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: RR instance with a slave model
// plus a fixed-priority instance with a trivial always-ready slave.
module tb_axi_rd_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [7:0]  len;
  } req_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [DW-1:0]   s_rdata, m_rdata;
  logic [1:0]      s_rresp, m_rresp, m_arburst, m_arlock;
  logic            s_rlast, m_rlast, m_rvalid, m_rready;
  logic [IW-1:0]   m_arid, m_rid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize, m_arprot;
  logic [3:0]      m_arcache;
  logic            m_arvalid, m_arready;

  axi_rd_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW),
                   .ID_W(IW), .ARB_MODE(0)) u_dut (
    .aclk(clk), .areset(areset),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready));

  logic [N-1:0]    fp_arvalid, fp_s_arready, fp_s_rvalid;
  logic [DW-1:0]   fp_s_rdata;
  logic [1:0]      fp_s_rresp, fp_m_arburst, fp_m_arlock;
  logic            fp_s_rlast, fp_m_arvalid, fp_m_rready;
  logic [IW-1:0]   fp_m_arid;
  logic [IW-1:0]   fp_rid = '0;
  logic [AW-1:0]   fp_m_araddr;
  logic [7:0]      fp_m_arlen;
  logic [2:0]      fp_m_arsize, fp_m_arprot;
  logic [3:0]      fp_m_arcache;

  axi_rd_arbiter #(.NUM_MST(N), .ADDR_W(AW), .DATA_W(DW),
                   .ID_W(IW), .ARB_MODE(1)) u_fp (
    .aclk(clk), .areset(areset),
    .s_arvalid(fp_arvalid), .s_araddr({32'h0000_0200, 32'h0000_0100}),
    .s_arlen('0), .s_arsize('0), .s_arburst('0),
    .s_arready(fp_s_arready), .s_rvalid(fp_s_rvalid),
    .s_rready(2'b11), .s_rdata(fp_s_rdata),
    .s_rresp(fp_s_rresp), .s_rlast(fp_s_rlast),
    .m_arid(fp_m_arid), .m_araddr(fp_m_araddr), .m_arlen(fp_m_arlen),
    .m_arsize(fp_m_arsize), .m_arburst(fp_m_arburst),
    .m_arlock(fp_m_arlock), .m_arcache(fp_m_arcache),
    .m_arprot(fp_m_arprot), .m_arvalid(fp_m_arvalid),
    .m_arready(1'b1), .m_rid(fp_rid), .m_rdata(32'h0000_abcd),
    .m_rresp(2'b00), .m_rlast(1'b1), .m_rvalid(1'b1),
    .m_rready(fp_m_rready));

  req_t  mq[N][$];
  req_t  ar_q[$];
  beat_t r_q[$];
  int    fp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    stall_req = 0;
  int    stall_cnt = 0;
  int    rx_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input int m, input logic [31:0] a,
                       input logic [7:0] len);
    req_t  r;
    beat_t b;
    r.m = m; r.addr = a; r.len = len;
    mq[m].push_back(r);
    ar_q.push_back(r);
    for (int i = 0; i <= int'(len); i++) begin
      b.m = m; b.data = a + 32'(i); b.last = (i == int'(len));
      r_q.push_back(b);
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((ar_q.size() + r_q.size()) != 0 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    check({nm, "_drain"}, 64'(ar_q.size() + r_q.size()), 64'(0));
    ar_q.delete();
    r_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // master AR drivers: hold valid until handshake, then load next
  initial begin : drv
    logic [N-1:0] hs;
    req_t r;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0;
    forever begin
      @(negedge clk);
      hs = s_arvalid & s_arready;
      @(posedge clk); #1;
      for (int m = 0; m < N; m++) begin
        if (hs[m]) s_arvalid[m] = 1'b0;
        if (!s_arvalid[m] && mq[m].size() > 0) begin
          r = mq[m].pop_front();
          s_arvalid[m]         = 1'b1;
          s_araddr[m*AW +: AW] = r.addr;
          s_arlen[m*8 +: 8]    = r.len;
          s_arsize[m*3 +: 3]   = 3'd2;
          s_arburst[m*2 +: 2]  = 2'b01;
        end
      end
    end
  end

  // slave model: data = burst address + beat index
  initial begin : slv
    logic arh, rh, arv, rst, lst, busy;
    logic [31:0] caddr;
    logic [7:0]  clen;
    logic [3:0]  cid;
    int wait_cnt, beat;
    busy = 1'b0; wait_cnt = 0; beat = 0;
    caddr = '0; clen = '0; cid = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    forever begin
      @(negedge clk);
      arh = m_arvalid & m_arready;
      rh  = m_rvalid & m_rready;
      arv = m_arvalid;
      rst = areset;
      lst = m_rlast;
      if (arh) begin
        caddr = m_araddr; clen = m_arlen; cid = m_arid;
      end
      @(posedge clk); #1;
      if (rst) begin
        busy = 1'b0; wait_cnt = 0;
      end else begin
        if (rh) begin
          if (lst) busy = 1'b0;
          else beat++;
        end
        if (arh) begin
          busy = 1'b1; beat = 0; wait_cnt = 0;
        end else if (arv) begin
          wait_cnt++;
        end
      end
      m_arready = !rst && (wait_cnt >= stall_req);
      m_rvalid  = busy;
      m_rid     = cid;
      m_rdata   = caddr + 32'(beat);
      m_rlast   = (beat == int'(clen));
      m_rresp   = 2'b00;
    end
  end

  always @(negedge clk) begin
    if (!areset && m_arvalid) begin
      if (ar_q.size() == 0) begin
        check("ar_spurious", 64'(m_arvalid), 64'(0));
      end else begin
        check("arid", 64'(m_arid), 64'(ar_q[0].m));
        check("araddr", 64'(m_araddr), 64'(ar_q[0].addr));
        check("arlen", 64'(m_arlen), 64'(ar_q[0].len));
        check("arsize_burst", 64'({m_arsize, m_arburst}),
              64'({3'd2, 2'b01}));
        check("ar_tieoff", 64'({m_arlock, m_arcache, m_arprot}),
              64'(0));
        check("s_arready", 64'(s_arready),
              m_arready ? (64'(1) << ar_q[0].m) : 64'(0));
        if (m_arready) void'(ar_q.pop_front());
        else stall_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (!areset) begin
      if (r_q.size() == 0) begin
        if (s_rvalid != 0 || m_rready)
          check("r_spurious", 64'({s_rvalid, m_rready}), 64'(0));
      end else if (m_rvalid) begin
        e = r_q[0];
        check("s_rvalid", 64'(s_rvalid), 64'(1) << e.m);
        check("m_rready", 64'(m_rready), 64'(s_rready[e.m]));
        if (s_rready[e.m]) begin
          check("rdata", 64'(s_rdata), 64'(e.data));
          check("rlast_rresp", 64'({s_rlast, s_rresp}),
                64'({e.last, 2'b00}));
          void'(r_q.pop_front());
          rx_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!areset && fp_m_arvalid) begin
      fp_rid <= fp_m_arid;
      if (fp_q.size() > 0) begin
        check("fp_arid", 64'(fp_m_arid), 64'(fp_q[0]));
        check("fp_araddr", 64'(fp_m_araddr),
              (fp_q[0] == 0) ? 64'h100 : 64'h200);
        check("fp_arfields", 64'({fp_m_arlen, fp_m_arsize,
              fp_m_arburst, fp_m_arlock, fp_m_arcache, fp_m_arprot}),
              64'(0));
        void'(fp_q.pop_front());
      end
    end
  end

  task automatic fp_wait();
    int t;
    t = 0;
    while (fp_q.size() != 0 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    check("fp_drain", 64'(fp_q.size()), 64'(0));
    fp_q.delete();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rx0, st0;
    s_rready = 2'b11;
    fp_arvalid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valids", 64'({m_arvalid, m_rready, s_arready, s_rvalid}),
          64'(0));
    check("rst_arfields", 64'({m_arid, m_arlen, m_arsize, m_arburst}),
          64'(0));
    check("rst_araddr", 64'(m_araddr), 64'(0));
    check("rst_tieoff", 64'({m_arlock, m_arcache, m_arprot}), 64'(0));
    check("fp_rst_valids", 64'({fp_m_arvalid, fp_m_rready,
          fp_s_arready, fp_s_rvalid}), 64'(0));
    check("fp_r_bcast", 64'({fp_s_rdata, fp_s_rresp, fp_s_rlast}),
          64'({32'h0000_abcd, 2'b00, 1'b1}));
    @(posedge clk); #1;
    areset = 1'b0;

    // T1: single burst, 1-cycle AR latency
    @(negedge clk);
    issue(0, 32'h1c00_0000, 8'd3);
    @(negedge clk); #1;
    check("t1_lat_idle", 64'({s_arvalid, m_arvalid}), 64'({2'b01, 1'b0}));
    @(negedge clk); #1;
    check("t1_lat_addr", 64'(m_arvalid), 64'(1));
    drain("t1");
    check("t1_idle", 64'({m_arvalid, m_rready, s_rvalid}), 64'(0));

    // T2: RR, both requesting; last grant was 0 so 1 goes first
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      issue(1, 32'h2000_0000 + 32'(k * 16), 8'd0);
      issue(0, 32'h3000_0000 + 32'(k * 16), 8'd0);
    end
    drain("t2");

    // T3: fixed priority
    fp_q = '{0, 0, 0, 0};
    @(posedge clk); #1;
    fp_arvalid = 2'b11;
    fp_wait();
    @(posedge clk); #1;
    fp_arvalid = 2'b10;
    fp_q = '{1, 1};
    fp_wait();
    @(posedge clk); #1;
    fp_arvalid = 2'b00;

    // T4: AR stalled 5 cycles
    @(posedge clk); #1;
    stall_req = 5;
    st0 = stall_cnt;
    @(negedge clk);
    issue(0, 32'h4000_0040, 8'd1);
    drain("t4");
    check("t4_stall_cycles", 64'(stall_cnt - st0), 64'(5));
    stall_req = 0;

    // T5: len-7 burst with s_rready[1] toggling
    @(negedge clk);
    issue(1, 32'h5000_0000, 8'd7);
    for (int t = 0; t < 200 && (ar_q.size() + r_q.size()) != 0; t++) begin
      @(posedge clk); #1;
      s_rready[1] = ~s_rready[1];
    end
    s_rready = 2'b11;
    drain("t5");

    // T6: reset mid-burst, then round-robin restarts at master 0
    @(negedge clk);
    issue(0, 32'h6000_0000, 8'd0);
    drain("t6_pre");
    rx0 = rx_cnt;
    @(negedge clk);
    issue(1, 32'h7000_0000, 8'd3);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #1;
      if (r_q.size() == 2) break;
    end
    @(posedge clk); #1;
    areset = 1'b1;
    @(negedge clk); #1;
    ar_q.delete();
    r_q.delete();
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk); #1;
    check("t6_beats", 64'(rx_cnt - rx0), 64'(2));
    check("t6_valids", 64'({m_arvalid, m_rready, s_arready, s_rvalid}),
          64'(0));
    check("t6_arfields", 64'({m_arid, m_arlen, m_araddr}), 64'(0));
    issue(0, 32'h8000_0000, 8'd0);
    issue(1, 32'h8000_1000, 8'd0);
    drain("t6_rr");
    issue(1, 32'h9000_0000, 8'd1);
    drain("t6_m1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
